clock_divider_ctrl: RTL and testbench

//   Run-time controller for the clock-division datapath: owns the half-period counter and out_clk

---
 rtl/clock_divider_ctrl_if.sv | 9 +
 rtl/clock_divider_ctrl.sv | 84 ++++++++
 tb/tb_clock_divider_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/clock_divider_ctrl_if.sv
// clock_divider_ctrl_if: valid/ready configuration port carrying a new half-period.
interface clock_divider_ctrl_if #(parameter int WIDTH = 16);
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_half;
  logic             cfg_ready;
  logic             cfg_err;
  modport master (output cfg_valid, cfg_half, input cfg_ready, cfg_err);
  modport slave (input cfg_valid, cfg_half, output cfg_ready, cfg_err);
endinterface

// File: rtl/clock_divider_ctrl.sv
// clock_divider_ctrl: glitch-free run-time clock divider with ratio changes applied at full-period boundaries.
module clock_divider_ctrl #(
  parameter int WIDTH        = 16,
  parameter int DEFAULT_HALF = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  clock_divider_ctrl_if.slave   cfg,
  output logic                  out_clk,
  output logic                  tick,
  output logic                  running
);
  typedef enum logic [1:0] {IDLE, RUN, PENDING, STOPPING} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] counter, counter_n, half_reg, half_n, pend_reg, pend_n;
  logic             pend_valid, pv_n, out_n, tick_n, err_n;
  logic             xfer, good, tc, fall, stop;
  assign cfg.cfg_ready = state == IDLE || state == RUN;
  assign running       = state != IDLE;
  assign xfer          = cfg.cfg_valid && cfg.cfg_ready;
  assign good          = xfer && |cfg.cfg_half;
  assign tc            = counter == half_reg - WIDTH'(1);
  assign fall          = tc && out_clk;
  assign stop          = state == STOPPING || !enable;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state       <= IDLE;
      counter     <= '0;
      half_reg    <= WIDTH'(DEFAULT_HALF);
      pend_reg    <= '0;
      pend_valid  <= 1'b0;
      out_clk     <= 1'b0;
      tick        <= 1'b0;
      cfg.cfg_err <= 1'b0;
    end else begin
      state       <= state_n;
      counter     <= counter_n;
      half_reg    <= half_n;
      pend_reg    <= pend_n;
      pend_valid  <= pv_n;
      out_clk     <= out_n;
      tick        <= tick_n;
      cfg.cfg_err <= err_n;
    end
  // Stopping while low, or on the falling terminal count, parks in IDLE with out_clk low so no runt appears.
  always_comb begin
    state_n   = state;
    counter_n = counter;
    half_n    = half_reg;
    pend_n    = pend_reg;
    pv_n      = pend_valid;
    out_n     = out_clk;
    tick_n    = 1'b0;
    err_n     = xfer && !(|cfg.cfg_half);
    if (state == IDLE) begin
      half_n    = good ? cfg.cfg_half : half_reg;
      state_n   = enable ? RUN : IDLE;
      counter_n = '0;
    end else begin
      counter_n = tc ? '0 : counter + WIDTH'(1);
      out_n     = tc ? !out_clk : out_clk;
      tick_n    = tc;
      pend_n    = good ? cfg.cfg_half : pend_reg;
      pv_n      = pend_valid || good;
      if (stop && (!out_clk || fall)) begin
        state_n   = IDLE;
        counter_n = '0;
        out_n     = 1'b0;
        tick_n    = fall;
        half_n    = pv_n ? pend_n : half_reg;
        pv_n      = 1'b0;
      end else if (stop) begin
        state_n = STOPPING;
      end else if (fall && pend_valid) begin
        state_n = RUN;
        half_n  = pend_reg;
        pv_n    = 1'b0;
      end else if (good) begin
        state_n = PENDING;
      end
    end
  end
endmodule

// File: tb/tb_clock_divider_ctrl.sv
// tb_clock_divider_ctrl: directed scenarios plus random traffic, checked against a period-position model.
module tb_clock_divider_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic out_clk, tick, running;
  int   checks = 0;
  int   errors = 0;
  clock_divider_ctrl_if #(.WIDTH(16)) cfg();
  clock_divider_ctrl #(.WIDTH(16), .DEFAULT_HALF(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg(cfg),
    .out_clk(out_clk), .tick(tick), .running(running)
  );
  always #5 clk = ~clk;
  // Model: position within the current output period (0..2H-1); out_clk is high for the second half.
  bit m_run, m_stop, m_out, m_tick, m_err;
  int m_h, m_pos;
  int m_pend[$];
  function automatic bit m_ready();
    return !m_run || (m_pend.size() == 0 && !m_stop);
  endfunction
  function automatic logic [4:0] exp_vec();
    return {m_ready(), m_run, m_out, m_tick, m_err};
  endfunction
  function automatic logic [4:0] dut_vec();
    return {cfg.cfg_ready, running, out_clk, tick, cfg.cfg_err};
  endfunction
  task automatic model_reset();
    m_run = 0; m_stop = 0; m_out = 0; m_tick = 0; m_err = 0;
    m_h = 2; m_pos = 0;
    m_pend.delete();
  endtask
  task automatic model_step();
    bit x, old, had, pend_end, halt;
    int p;
    x = cfg.cfg_valid && m_ready();
    old = m_out;
    m_err = x && cfg.cfg_half == 0;
    if (!m_run) begin
      if (x && cfg.cfg_half != 0) m_h = int'(cfg.cfg_half);
      if (enable) begin m_run = 1; m_pos = 0; end
    end else begin
      p = m_pos + 1;
      pend_end = p == 2 * m_h;
      had = m_pend.size() > 0;
      halt = m_stop || !enable;
      if (x && cfg.cfg_half != 0) m_pend.push_back(int'(cfg.cfg_half));
      if (halt && (!old || pend_end)) begin
        m_run = 0; m_stop = 0; m_pos = 0;
        if (m_pend.size() > 0) m_h = m_pend.pop_front();
      end else if (halt) begin
        m_stop = 1; m_pos = p;
      end else if (pend_end) begin
        m_pos = 0;
        if (had) m_h = m_pend.pop_front();
      end else m_pos = p;
    end
    m_out = m_run && m_pos >= m_h;
    m_tick = m_out != old;
  endtask
  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask
  task automatic test_reset();
    cfg.cfg_valid = 0; cfg.cfg_half = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_clk, tick, cfg.cfg_err, running} !== 4'b0000) begin
      errors++; $display("FAIL reset_hold got %b exp 0000", {out_clk, tick, cfg.cfg_err, running});
    end
    model_reset();
    reset = 1;
    #1;
    checks++;
    if (dut_vec() !== 5'b10000) begin errors++; $display("FAIL reset_release got %b exp 10000", dut_vec()); end
  endtask
  task automatic test_default_run();
    int first_rise, ticks;
    first_rise = -1; ticks = 0;
    enable = 1;
    for (int i = 1; i <= 16; i++) begin
      advance();
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL default_run cyc %0d got %b exp %b", i, dut_vec(), exp_vec()); end
      if (tick) ticks++;
      if (out_clk && first_rise < 0) first_rise = i;
    end
    checks++;
    if (first_rise != 3) begin errors++; $display("FAIL default_first_rise got %0d exp 3", first_rise); end
    checks++;
    if (ticks != 7) begin errors++; $display("FAIL default_ticks got %0d exp 7", ticks); end
  endtask
  task automatic test_ratio_change();
    int last_rise, min_per, n;
    last_rise = -1; min_per = 1000;
    for (n = 0; n < 20 && !(tick && out_clk); n++) begin
      advance();
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL ratio_wait got %b exp %b", dut_vec(), exp_vec()); end
    end
    checks++;
    if (!(tick && out_clk)) begin errors++; $display("FAIL ratio_wait_rise timeout got %b exp 1", out_clk); end
    cfg.cfg_valid = 1; cfg.cfg_half = 16'd5;
    advance();
    cfg.cfg_valid = 0;
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL ratio_change cyc %0d got %b exp %b", i, dut_vec(), exp_vec()); end
      if (tick && out_clk) begin
        if (last_rise >= 0 && i - last_rise < min_per) min_per = i - last_rise;
        last_rise = i;
      end
      advance();
    end
    checks++;
    if (min_per < 4) begin errors++; $display("FAIL ratio_min_period got %0d exp >=4", min_per); end
  endtask
  task automatic test_cfg_zero();
    cfg.cfg_valid = 1; cfg.cfg_half = '0;
    advance();
    cfg.cfg_valid = 0;
    checks++;
    if ({cfg.cfg_err, running} !== 2'b11) begin errors++; $display("FAIL cfg_zero_err got %b exp 11", {cfg.cfg_err, running}); end
    for (int i = 0; i < 12; i++) begin
      advance();
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL cfg_zero cyc %0d got %b exp %b", i, dut_vec(), exp_vec()); end
    end
  endtask
  task automatic test_stop_high();
    int k, n;
    cfg.cfg_valid = 1; cfg.cfg_half = 16'd3;
    advance();
    cfg.cfg_valid = 0;
    for (int i = 0; i < 25; i++) begin
      advance();
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL stop_setup cyc %0d got %b exp %b", i, dut_vec(), exp_vec()); end
    end
    for (n = 0; n < 20 && !(tick && out_clk); n++) advance();
    checks++;
    if (!(tick && out_clk)) begin errors++; $display("FAIL stop_wait_rise timeout got %b exp 1", out_clk); end
    advance();
    enable = 0;
    k = 1;
    for (n = 0; n < 10 && out_clk; n++) begin
      advance();
      k++;
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL stop_high cyc %0d got %b exp %b", n, dut_vec(), exp_vec()); end
    end
    checks++;
    if (k != 3) begin errors++; $display("FAIL stop_high_len got %0d exp 3", k); end
    advance();
    checks++;
    if ({running, out_clk} !== 2'b00) begin errors++; $display("FAIL stop_idle got %b exp 00", {running, out_clk}); end
  endtask
  task automatic test_stop_pending();
    int n, rise;
    enable = 1;
    for (n = 0; n < 30 && !(tick && !out_clk); n++) begin
      advance();
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL pend_wait got %b exp %b", dut_vec(), exp_vec()); end
    end
    checks++;
    if (!(tick && !out_clk)) begin errors++; $display("FAIL pend_wait_fall timeout got %b exp 0", out_clk); end
    cfg.cfg_valid = 1; cfg.cfg_half = 16'd7;
    advance();
    cfg.cfg_valid = 0; enable = 0;
    advance();
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL pend_stop_idle got %b exp 0", running); end
    enable = 1;
    rise = -1;
    for (n = 1; n <= 20 && rise < 0; n++) begin
      advance();
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL pend_restart cyc %0d got %b exp %b", n, dut_vec(), exp_vec()); end
      if (out_clk) rise = n;
    end
    checks++;
    if (rise != 8) begin errors++; $display("FAIL pend_first_rise got %0d exp 8", rise); end
  endtask
  task automatic test_reset_mid();
    int n;
    for (n = 0; n < 30 && !(tick && out_clk); n++) advance();
    cfg.cfg_valid = 1; cfg.cfg_half = 16'd9;
    advance();
    cfg.cfg_valid = 0;
    checks++;
    if ({cfg.cfg_ready, out_clk} !== 2'b01) begin errors++; $display("FAIL rmid_pending got %b exp 01", {cfg.cfg_ready, out_clk}); end
    #2 reset = 0;
    #1;
    checks++;
    if ({out_clk, running} !== 2'b00) begin errors++; $display("FAIL rmid_async got %b exp 00", {out_clk, running}); end
    @(negedge clk);
    model_reset();
    reset = 1;
    for (int i = 0; i < 16; i++) begin
      advance();
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL rmid_after cyc %0d got %b exp %b", i, dut_vec(), exp_vec()); end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      enable = $urandom_range(0, 19) != 0;
      cfg.cfg_valid = $urandom_range(0, 3) == 0;
      cfg.cfg_half = 16'($urandom_range(0, 6));
      advance();
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL random cyc %0d got %b exp %b", i, dut_vec(), exp_vec()); end
    end
    cfg.cfg_valid = 0;
  endtask
  initial begin
    test_reset();
    test_default_run();
    test_ratio_change();
    test_cfg_zero();
    test_stop_high();
    test_stop_pending();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
